// File: rtl/led_runner.sv
// LED chaser: a prescaled step strobe drives rotate, bounce or blink patterns
// on N_LED outputs, with a one-cycle tick marking each visible update.
module led_runner #(
    parameter int N_LED      = 6,
    parameter int TICK_DIV   = 6500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led,
    output logic             tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [N_LED-1:0] PAT_FIRST = N_LED'(1);

    typedef enum logic [1:0] {
        MODE_ROT_LEFT  = 2'b00,
        MODE_ROT_RIGHT = 2'b01,
        MODE_BOUNCE    = 2'b10,
        MODE_BLINK     = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [CW-1:0]    cnt, cnt_next;
    logic [N_LED-1:0] pattern, pattern_next;
    dir_t             dir, dir_next;
    mode_t            mode_q, mode_q_next;
    logic             mode_chg;
    logic             stb;
    logic             one_hot;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt     <= '0;
            pattern <= PAT_FIRST;
            dir     <= DIR_LEFT;
            mode_q  <= MODE_ROT_LEFT;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            pattern <= pattern_next;
            dir     <= dir_next;
            mode_q  <= mode_q_next;
            tick    <= stb;
        end
    end

    // A mode change always wins over a step, so the new pattern is shown for a
    // full prescaler period before it first advances.
    always_comb begin
        cnt_next     = cnt;
        pattern_next = pattern;
        dir_next     = dir;
        mode_q_next  = mode_q;
        mode_chg     = (mode != mode_q);
        stb          = en && (cnt == CNT_LAST) && !mode_chg;
        one_hot      = (pattern != '0) && ((pattern & (pattern - PAT_FIRST)) == '0);

        if (mode_chg) begin
            mode_q_next  = mode_t'(mode);
            cnt_next     = '0;
            dir_next     = DIR_LEFT;
            pattern_next = (mode_t'(mode) == MODE_BLINK) ? '1 : PAT_FIRST;
        end else if (en) begin
            cnt_next = stb ? '0 : (cnt + CNT_ONE);
            if (stb) begin
                if (mode_q != MODE_BLINK && !one_hot) begin
                    pattern_next = PAT_FIRST;
                end else begin
                    case (mode_q)
                        MODE_ROT_LEFT:  pattern_next = {pattern[N_LED-2:0], pattern[N_LED-1]};
                        MODE_ROT_RIGHT: pattern_next = {pattern[0], pattern[N_LED-1:1]};
                        MODE_BOUNCE: begin
                            if (dir == DIR_LEFT) begin
                                if (pattern[N_LED-1]) begin
                                    dir_next     = DIR_RIGHT;
                                    pattern_next = pattern >> 1;
                                end else begin
                                    pattern_next = pattern << 1;
                                end
                            end else begin
                                if (pattern[0]) begin
                                    dir_next     = DIR_LEFT;
                                    pattern_next = pattern << 1;
                                end else begin
                                    pattern_next = pattern >> 1;
                                end
                            end
                        end
                        MODE_BLINK:     pattern_next = ~pattern;
                        default:        pattern_next = PAT_FIRST;
                    endcase
                end
            end
        end
    end

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign led = ~pattern;
        end else begin : g_active_high
            assign led = pattern;
        end
    endgenerate

endmodule

// File: tb/tb_led_runner.sv
// Bench for led_runner: a phase-based reference model checked every cycle on
// two instances (active-high and active-low LEDs), plus literal spot checks.
module tb_led_runner;

    localparam int N_LED    = 4;
    localparam int TICK_DIV = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [N_LED-1:0] led;
    logic [N_LED-1:0] led_inv;
    logic             tick;
    logic             tick_inv;
    bit               clk_run = 1'b1;

    int n_compared = 0;
    int n_mismatch = 0;

    int         m_cnt  = 0;
    int         m_pos  = 0;
    bit         m_on   = 1'b0;
    bit         m_tick = 1'b0;
    logic [1:0] m_mode = 2'b00;

    led_runner #(.N_LED(N_LED), .TICK_DIV(TICK_DIV), .ACTIVE_LOW(0)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (en),
        .mode     (mode),
        .led      (led),
        .tick     (tick)
    );

    led_runner #(.N_LED(N_LED), .TICK_DIV(TICK_DIV), .ACTIVE_LOW(1)) dut_inv (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (en),
        .mode     (mode),
        .led      (led_inv),
        .tick     (tick_inv)
    );

    always begin
        #5;
        if (clk_run) sys_clk = ~sys_clk;
    end

    // The model tracks a position or bounce phase rather than a shifted vector.
    function automatic logic [N_LED-1:0] model_pattern();
        int p;
        case (m_mode)
            2'b00, 2'b01: return N_LED'(1 << m_pos);
            2'b10: begin
                p = (m_pos < N_LED) ? m_pos : (2 * N_LED - 2 - m_pos);
                return N_LED'(1 << p);
            end
            default: return m_on ? '1 : '0;
        endcase
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        bit chg;
        bit step;
        if (!sys_rst_n) begin
            m_cnt  = 0;
            m_pos  = 0;
            m_on   = 1'b0;
            m_tick = 1'b0;
            m_mode = 2'b00;
        end else begin
            chg    = (mode != m_mode);
            step   = en && (m_cnt == TICK_DIV - 1) && !chg;
            m_tick = step;
            if (chg) begin
                m_mode = mode;
                m_cnt  = 0;
                m_pos  = 0;
                m_on   = (mode == 2'b11);
            end else if (en) begin
                if (step) begin
                    m_cnt = 0;
                    case (m_mode)
                        2'b00:   m_pos = (m_pos + 1) % N_LED;
                        2'b01:   m_pos = (m_pos + N_LED - 1) % N_LED;
                        2'b10:   m_pos = (m_pos + 1) % (2 * N_LED - 2);
                        default: m_on  = !m_on;
                    endcase
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge sys_clk) begin
        logic [N_LED-1:0] exp_pat;
        logic [N_LED-1:0] exp_inv;
        exp_pat = model_pattern();
        exp_inv = ~exp_pat;
        check_output("model_led",      32'(led),      32'(exp_pat));
        check_output("model_led_inv",  32'(led_inv),  32'(exp_inv));
        check_output("model_tick",     32'(tick),     32'(m_tick));
        check_output("model_tick_inv", 32'(tick_inv), 32'(m_tick));
    end

    task automatic expect_state(input string name, input logic [N_LED-1:0] exp_led,
                                input logic exp_tick);
        logic [N_LED-1:0] exp_inv;
        exp_inv = ~exp_led;
        check_output({name, "_led"},     32'(led),     32'(exp_led));
        check_output({name, "_led_inv"}, 32'(led_inv), 32'(exp_inv));
        check_output({name, "_tick"},    32'(tick),    32'(exp_tick));
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    endtask

    logic [N_LED-1:0] bounce_seq [7];

    initial begin
        sys_rst_n = 1'b0;
        en        = 1'b1;
        mode      = 2'b00;
        #12;
        expect_state("reset", 4'b0001, 1'b0);
        sys_rst_n = 1'b1;

        cycle(3); expect_state("rot_hold",   4'b0001, 1'b0);
        cycle(1); expect_state("rot_step1",  4'b0010, 1'b1);
        cycle(1); expect_state("rot_tick0",  4'b0010, 1'b0);
        cycle(3); expect_state("rot_step2",  4'b0100, 1'b1);
        cycle(4); expect_state("rot_step3",  4'b1000, 1'b1);
        cycle(4); expect_state("rot_wrap",   4'b0001, 1'b1);

        // Switch to rotate-right exactly when the count sits at its terminal value.
        cycle(3); mode = 2'b01;
        cycle(1); expect_state("mc_cycle",   4'b0001, 1'b0);
        cycle(1); expect_state("mc_next",    4'b0001, 1'b0);
        cycle(2); expect_state("mc_hold",    4'b0001, 1'b0);
        cycle(1); expect_state("rotr_step1", 4'b1000, 1'b1);
        cycle(4); expect_state("rotr_step2", 4'b0100, 1'b1);

        mode = 2'b10;
        cycle(1); expect_state("bnc_load",   4'b0001, 1'b0);
        cycle(2); expect_state("pre_pause",  4'b0001, 1'b0);
        en = 1'b0;
        cycle(10); expect_state("pause",     4'b0001, 1'b0);
        en = 1'b1;
        cycle(1); expect_state("resume1",    4'b0001, 1'b0);
        cycle(1); expect_state("resume2",    4'b0010, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bounce_seq[i] = (i == 0) ? 4'b0100 : (i == 1) ? 4'b1000 : (i == 2) ? 4'b0100 :
                            (i == 3) ? 4'b0010 : (i == 4) ? 4'b0001 : 4'b0010;
            cycle(4); expect_state("bnc_run", bounce_seq[i], 1'b1);
        end

        // Stop the clock just after a step, then reset with no edge available.
        @(negedge sys_clk);
        clk_run = 1'b0;
        #1; expect_state("pre_rst", 4'b0010, 1'b1);
        #1; sys_rst_n = 1'b0;
        #1; expect_state("async_rst", 4'b0001, 1'b0);
        #5; sys_rst_n = 1'b1;
        #1; clk_run = 1'b1;

        cycle(1); expect_state("rst_mc", 4'b0001, 1'b0);
        bounce_seq[0] = 4'b0010; bounce_seq[1] = 4'b0100; bounce_seq[2] = 4'b1000;
        bounce_seq[3] = 4'b0100; bounce_seq[4] = 4'b0010; bounce_seq[5] = 4'b0001;
        bounce_seq[6] = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            cycle(4); expect_state("bnc_full", bounce_seq[i], 1'b1);
        end

        en   = 1'b0;
        mode = 2'b11;
        cycle(1); expect_state("blink_load", 4'b1111, 1'b0);
        cycle(5); expect_state("blink_frz",  4'b1111, 1'b0);
        en = 1'b1;
        cycle(4); expect_state("blink1",     4'b0000, 1'b1);
        cycle(4); expect_state("blink2",     4'b1111, 1'b1);
        cycle(4); expect_state("blink3",     4'b0000, 1'b1);

        mode = 2'b00;
        cycle(1); expect_state("back_rot",   4'b0001, 1'b0);
        cycle(4); expect_state("back_step",  4'b0010, 1'b1);

        finish_run();
    end

    initial begin
        #200000;
        n_mismatch++;
        $display("[TB] FAIL watchdog: run did not complete within time limit");
        finish_run();
    end

endmodule
